// File: rtl/sha_job_arbiter.sv
// Two-requester, job-granular arbiter in front of one message_build datapath.
// A grant covers the config, every input beat and every padded output block of one job.
module sha_job_arbiter #(
  parameter int DATA_W = 512,
  parameter int SIZE_W = 64,
  parameter int CNT_W  = SIZE_W - 9 + 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [SIZE_W-1:0] req0_cfg_size,
  input  logic [1:0]        req0_cfg_scheme,
  input  logic              req0_cfg_valid,
  output logic              req0_cfg_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_data_valid,
  output logic              req0_data_ready,
  input  logic [SIZE_W-1:0] req1_cfg_size,
  input  logic [1:0]        req1_cfg_scheme,
  input  logic              req1_cfg_valid,
  output logic              req1_cfg_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_data_valid,
  output logic              req1_data_ready,
  output logic [SIZE_W-1:0] mb_cfg_size,
  output logic [1:0]        mb_cfg_scheme,
  output logic              mb_cfg_valid,
  input  logic              mb_cfg_ready,
  output logic [DATA_W-1:0] mb_data,
  output logic              mb_data_valid,
  input  logic              mb_data_ready,
  input  logic              mb_out_valid,
  input  logic              mb_out_ready,
  output logic              busy,
  output logic              owner,
  output logic              job_done,
  output logic              job_done_id
);
  typedef enum logic [1:0] {S_IDLE, S_CFG, S_DATA, S_DRAIN} state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_busy;
  logic              r_job_done;
  logic              r_job_done_id;
  logic              r_mb_cfg_valid;
  logic [SIZE_W-1:0] r_mb_cfg_size;
  logic [1:0]        r_mb_cfg_scheme;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_out_cnt;

  logic              w_other_valid;
  logic              w_grant;
  logic              w_take;
  logic [SIZE_W-1:0] w_size;
  logic [1:0]        w_scheme;
  logic [SIZE_W:0]   w_in_sum;
  logic [SIZE_W:0]   w_out_sum;
  logic [CNT_W-1:0]  w_in_cnt;
  logic [CNT_W-1:0]  w_out_cnt;
  logic [CNT_W-1:0]  w_out_next;
  logic              w_data_phase;
  logic              w_data_hs;
  logic              w_out_hs;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] cnt, input logic en);
    return (en && cnt != '0) ? cnt - CNT_W'(1) : cnt;
  endfunction

  // Round-robin: the requester that did not win last time has priority.
  assign w_other_valid  = r_last_grant ? req0_cfg_valid : req1_cfg_valid;
  assign w_grant        = w_other_valid ? ~r_last_grant : r_last_grant;
  assign w_take         = (r_state == S_IDLE) && (req0_cfg_valid || req1_cfg_valid);
  assign req0_cfg_ready = w_take && !w_grant;
  assign req1_cfg_ready = w_take && w_grant;

  assign w_size    = w_grant ? req1_cfg_size : req0_cfg_size;
  assign w_scheme  = w_grant ? req1_cfg_scheme : req0_cfg_scheme;
  // Input beats = ceil(size/512); padded output blocks also cover the 1-bit marker and 64-bit length.
  assign w_in_sum  = {1'b0, w_size} + (SIZE_W+1)'(511);
  assign w_out_sum = {1'b0, w_size} + (SIZE_W+1)'(64);
  assign w_in_cnt  = CNT_W'(w_in_sum >> 9);
  assign w_out_cnt = CNT_W'(w_out_sum >> 9) + CNT_W'(1);

  assign w_data_phase    = (r_state == S_DATA);
  assign mb_data         = !w_data_phase ? '0 : (r_owner ? req1_data : req0_data);
  assign mb_data_valid   = w_data_phase && (r_owner ? req1_data_valid : req0_data_valid);
  assign req0_data_ready = w_data_phase && !r_owner && mb_data_ready;
  assign req1_data_ready = w_data_phase && r_owner && mb_data_ready;
  assign w_data_hs       = mb_data_valid && mb_data_ready;
  assign w_out_hs        = mb_out_valid && mb_out_ready;
  assign w_out_next      = sat_dec(r_out_cnt, w_out_hs);

  assign mb_cfg_size   = r_mb_cfg_size;
  assign mb_cfg_scheme = r_mb_cfg_scheme;
  assign mb_cfg_valid  = r_mb_cfg_valid;
  assign busy          = r_busy;
  assign owner         = r_owner;
  assign job_done      = r_job_done;
  assign job_done_id   = r_job_done_id;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state         <= S_IDLE;
      r_last_grant    <= 1'b1;
      r_owner         <= 1'b0;
      r_busy          <= 1'b0;
      r_job_done      <= 1'b0;
      r_job_done_id   <= 1'b0;
      r_mb_cfg_valid  <= 1'b0;
      r_mb_cfg_size   <= '0;
      r_mb_cfg_scheme <= '0;
      r_in_cnt        <= '0;
      r_out_cnt       <= '0;
    end else begin
      r_job_done <= 1'b0;
      if (r_state != S_IDLE) r_out_cnt <= w_out_next;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_mb_cfg_size   <= w_size;
            r_mb_cfg_scheme <= w_scheme;
            r_in_cnt        <= w_in_cnt;
            r_out_cnt       <= w_out_cnt;
            r_owner         <= w_grant;
            r_last_grant    <= w_grant;
            r_busy          <= 1'b1;
            r_mb_cfg_valid  <= 1'b1;
            r_state         <= S_CFG;
          end
        end
        S_CFG: begin
          if (mb_cfg_ready) begin
            r_mb_cfg_valid <= 1'b0;
            r_state        <= (r_in_cnt != '0) ? S_DATA : S_DRAIN;
          end
        end
        S_DATA: begin
          if (w_data_hs) begin
            r_in_cnt <= r_in_cnt - CNT_W'(1);
            if (r_in_cnt == CNT_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_next == '0) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_job_done    <= 1'b1;
            r_job_done_id <= r_owner;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_job_arbiter.sv
// Bench for sha_job_arbiter: directed and random jobs checked against a transaction-level
// model of round-robin job granting, block counts and beat ordering.
module tb_sha_job_arbiter;
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [63:0]  psize [2];
  logic [1:0]   pscheme [2];
  logic         pend [2];
  logic         stg [2];
  logic [511:0] d_arr [2];
  logic         dv [2];
  logic         req0_cfg_ready, req1_cfg_ready, req0_data_ready, req1_data_ready;
  logic [63:0]  mb_cfg_size;
  logic [1:0]   mb_cfg_scheme;
  logic         mb_cfg_valid;
  logic         mb_cfg_ready = 1'b0;
  logic [511:0] mb_data;
  logic         mb_data_valid;
  logic         mb_data_ready = 1'b0;
  logic         mb_out_valid = 1'b0;
  logic         mb_out_ready = 1'b0;
  logic         busy, owner, job_done, job_done_id;

  int           n_chk = 0;
  int           n_err = 0;
  logic         m_last;
  logic         cur_own;
  logic [63:0]  cur_size;
  logic [1:0]   cur_scheme;

  always #5 clk = ~clk;

  sha_job_arbiter dut (
    .clk(clk), .nrst(nrst),
    .req0_cfg_size(psize[0]), .req0_cfg_scheme(pscheme[0]), .req0_cfg_valid(pend[0]),
    .req0_cfg_ready(req0_cfg_ready), .req0_data(d_arr[0]), .req0_data_valid(dv[0]),
    .req0_data_ready(req0_data_ready),
    .req1_cfg_size(psize[1]), .req1_cfg_scheme(pscheme[1]), .req1_cfg_valid(pend[1]),
    .req1_cfg_ready(req1_cfg_ready), .req1_data(d_arr[1]), .req1_data_valid(dv[1]),
    .req1_data_ready(req1_data_ready),
    .mb_cfg_size(mb_cfg_size), .mb_cfg_scheme(mb_cfg_scheme), .mb_cfg_valid(mb_cfg_valid),
    .mb_cfg_ready(mb_cfg_ready), .mb_data(mb_data), .mb_data_valid(mb_data_valid),
    .mb_data_ready(mb_data_ready), .mb_out_valid(mb_out_valid), .mb_out_ready(mb_out_ready),
    .busy(busy), .owner(owner), .job_done(job_done), .job_done_id(job_done_id)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic stage(input int r, input logic [63:0] sz, input logic [1:0] sch);
    psize[r]   = sz;
    pscheme[r] = sch;
    stg[r]     = 1'b1;
  endtask

  // Entered just after a sample point; new requests appear before the next active edge.
  task automatic do_grant(output logic ok);
    logic exp_g;
    ok = 1'b0;
    for (int r = 0; r < 2; r++) if (stg[r]) begin pend[r] = 1'b1; stg[r] = 1'b0; end
    exp_g = pend[!m_last] ? !m_last : m_last;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req0_cfg_ready || req1_cfg_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin chk1("grant_timeout", 1'b0, 1'b1); return; end
    chk1("grant_r0", req0_cfg_ready, !exp_g);
    chk1("grant_r1", req1_cfg_ready, exp_g);
    cur_own    = exp_g;
    m_last     = exp_g;
    cur_size   = psize[exp_g];
    cur_scheme = pscheme[exp_g];
    @(negedge clk); #1;
    chk1("cfg_rdy_after_grant", req0_cfg_ready | req1_cfg_ready, 1'b0);
    chk1("busy_after_grant", busy, 1'b1);
    chk1("owner", owner, cur_own);
    pend[cur_own] = 1'b0;
  endtask

  task automatic do_cfg();
    int dly;
    dly = $urandom_range(0, 2);
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk); mb_cfg_ready = (c == dly); #1;
      chk1("mb_cfg_valid_held", mb_cfg_valid, 1'b1);
    end
    chkw("mb_cfg_size", 512'(mb_cfg_size), 512'(cur_size));
    chkw("mb_cfg_scheme", 512'(mb_cfg_scheme), 512'(cur_scheme));
    @(negedge clk); mb_cfg_ready = 1'b0; #1;
    chk1("mb_cfg_valid_drop", mb_cfg_valid, 1'b0);
  endtask

  task automatic feed(input int n);
    logic [511:0] beats [$];
    int idx;
    logic vo, rd, own_rdy, oth_rdy;
    idx = 0;
    for (int i = 0; i < n; i++) beats.push_back(rand512());
    for (int c = 0; c < 2000 && idx < n; c++) begin
      @(negedge clk);
      vo = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      d_arr[cur_own]  = beats[idx];
      dv[cur_own]     = vo;
      d_arr[!cur_own] = rand512();
      dv[!cur_own]    = 1'($urandom_range(0, 1));
      mb_data_ready   = rd;
      #1;
      own_rdy = cur_own ? req1_data_ready : req0_data_ready;
      oth_rdy = cur_own ? req0_data_ready : req1_data_ready;
      chk1("nonowner_data_rdy", oth_rdy, 1'b0);
      chk1("owner_data_rdy", own_rdy, rd);
      chk1("mb_data_valid", mb_data_valid, vo);
      chk1("cfg_rdy_busy", req0_cfg_ready | req1_cfg_ready, 1'b0);
      if (vo && own_rdy) begin
        chkw("beat_order", mb_data, beats[idx]);
        idx++;
      end
    end
    if (idx < n) chk1("feed_timeout", 1'b0, 1'b1);
    @(negedge clk);
    dv[0] = 1'b0; dv[1] = 1'b0; mb_data_ready = 1'b0;
    #1;
  endtask

  task automatic drain(input int nout);
    int cnt;
    logic ov, orr;
    cnt = 0;
    for (int c = 0; c < 2000 && cnt < nout; c++) begin
      @(negedge clk);
      ov = 1'($urandom_range(0, 1));
      orr = 1'($urandom_range(0, 1));
      mb_out_valid = ov; mb_out_ready = orr;
      dv[cur_own] = 1'b1; d_arr[cur_own] = rand512(); mb_data_ready = 1'b1;
      #1;
      chk1("drain_owner_rdy", cur_own ? req1_data_ready : req0_data_ready, 1'b0);
      chk1("drain_mb_valid", mb_data_valid, 1'b0);
      chk1("done_early", job_done, 1'b0);
      chk1("drain_busy", busy, 1'b1);
      if (ov && orr) cnt++;
    end
    if (cnt < nout) chk1("drain_timeout", 1'b0, 1'b1);
    @(negedge clk);
    mb_out_valid = 1'b0; mb_out_ready = 1'b0; dv[cur_own] = 1'b0; mb_data_ready = 1'b0;
    #1;
    chk1("job_done", job_done, 1'b1);
    chk1("job_done_id", job_done_id, cur_own);
    chk1("busy_after_done", busy, 1'b0);
  endtask

  task automatic run_job();
    logic ok;
    int nin, nout;
    do_grant(ok);
    if (!ok) return;
    nin  = int'((cur_size + 64'd511) / 64'd512);
    nout = int'((cur_size + 64'd65 + 64'd511) / 64'd512);
    do_cfg();
    if (nin > 0) feed(nin);
    drain(nout);
  endtask

  initial begin
    m_last = 1'b1;
    for (int r = 0; r < 2; r++) begin
      psize[r] = '0; pscheme[r] = '0; pend[r] = 1'b0; stg[r] = 1'b0;
      d_arr[r] = '0; dv[r] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_job_done", job_done, 1'b0);
    chk1("rst_job_done_id", job_done_id, 1'b0);
    chk1("rst_mb_cfg_valid", mb_cfg_valid, 1'b0);
    chkw("rst_mb_cfg_size", 512'(mb_cfg_size), 512'd0);
    chk1("rst_mb_data_valid", mb_data_valid, 1'b0);
    @(negedge clk); nrst = 1'b1; #1;

    // Contention from reset, then alternation; covers sizes 448, 512, 1024 and 0.
    stage(0, 64'd448, 2'd2);
    stage(1, 64'd512, 2'd1);
    run_job();
    run_job();
    stage(0, 64'd1024, 2'd3);
    stage(1, 64'd0, 2'd0);
    run_job();
    run_job();

    // Output beats while idle must not start or finish anything.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mb_out_valid = 1'b1; mb_out_ready = 1'b1; #1;
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_job_done", job_done, 1'b0);
    end
    @(negedge clk); mb_out_valid = 1'b0; mb_out_ready = 1'b0; #1;
    stage(1, 64'd100, 2'd1);
    run_job();

    // Random traffic: 20 four-beat jobs from random requesters.
    for (int j = 0; j < 20; j++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1)
          stage(r, 64'd1537 + 64'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
      if (!pend[0] && !pend[1] && !stg[0] && !stg[1])
        stage(int'($urandom_range(0, 1)), 64'd1537 + 64'($urandom_range(0, 511)), 2'd0);
      run_job();
    end
    while (pend[0] || pend[1]) run_job();

    // Reset in the middle of a req0 data phase.
    stage(0, 64'd2048, 2'd1);
    begin
      logic ok;
      do_grant(ok);
      if (ok) begin
        do_cfg();
        feed(1);
      end
    end
    @(negedge clk);
    nrst = 1'b0; dv[0] = 1'b1; dv[1] = 1'b1; mb_data_ready = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_mb_data_valid", mb_data_valid, 1'b0);
    chk1("midrst_r0_data_rdy", req0_data_ready, 1'b0);
    chk1("midrst_r1_data_rdy", req1_data_ready, 1'b0);
    chk1("midrst_mb_cfg_valid", mb_cfg_valid, 1'b0);
    chk1("midrst_job_done", job_done, 1'b0);
    m_last = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    @(negedge clk);
    nrst = 1'b1; dv[0] = 1'b0; dv[1] = 1'b0; mb_data_ready = 1'b0;
    #1;
    chk1("post_rst_job_done", job_done, 1'b0);
    stage(0, 64'd960, 2'd2);
    stage(1, 64'd64, 2'd3);
    run_job();
    run_job();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
